// File: rtl/booth_mult_pkg.sv
// Shared types for the sequential Booth multiplier: FSM state encoding and
// the radix-2 Booth recoding of each {Q[0], q_m1} pair.
package booth_mult_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    BOOTH_NOP = 2'd0,
    BOOTH_ADD = 2'd1,
    BOOTH_SUB = 2'd2
  } booth_op_t;

  // 01 -> add M, 10 -> subtract M, 00/11 -> inside a run of equal bits, no-op
  function automatic booth_op_t booth_decode(input logic q0, input logic q_m1);
    booth_op_t op;
    case ({q0, q_m1})
      2'b01:   op = BOOTH_ADD;
      2'b10:   op = BOOTH_SUB;
      default: op = BOOTH_NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational radix-2 Booth step: conditional add/subtract of M into A,
// then arithmetic right shift of {A, Q, q_m1}.
module booth_step
  import booth_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH-1:0] q,
  input  logic             q_m1,
  input  logic [WIDTH:0]   m,
  output logic [WIDTH:0]   a_nxt,
  output logic [WIDTH-1:0] q_nxt,
  output logic             q_m1_nxt
);

  booth_op_t      op;
  logic [WIDTH:0] operand;
  logic           carry_in;
  logic [WIDTH:0] sum;

  // Subtraction is A + ~M + 1, so a single adder serves both directions.
  always_comb begin
    op       = booth_decode(q[0], q_m1);
    operand  = '0;
    carry_in = 1'b0;
    case (op)
      BOOTH_ADD: operand = m;
      BOOTH_SUB: begin
        operand  = ~m;
        carry_in = 1'b1;
      end
      default: operand = '0;
    endcase
    sum = a + operand + {{WIDTH{1'b0}}, carry_in};
  end

  assign a_nxt    = {sum[WIDTH], sum[WIDTH:1]};
  assign q_nxt    = {sum[0], q[WIDTH-1:1]};
  assign q_m1_nxt = q[0];

endmodule

// File: rtl/booth_multiplier_sequencer.sv
// Sequential signed Booth multiplier: one Booth step per clock, start/busy/done
// handshake, registered product that holds until the next result.
module booth_multiplier_sequencer
  import booth_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  state_t           state_next;
  logic             load;
  logic             step;
  logic             last_step;

  logic [WIDTH:0]   a_r;
  logic [WIDTH-1:0] q_r;
  logic             q_m1_r;
  logic [WIDTH:0]   m_r;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   a_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             q_m1_nxt;

  assign last_step = (count == CW'(1));

  // Handshake: start is only looked at in IDLE and DONE; a start seen in DONE
  // reloads immediately so results can be issued back to back.
  always_comb begin
    state_next = S_IDLE;
    load       = 1'b0;
    step       = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = S_RUN;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_RUN: begin
        busy       = 1'b1;
        step       = 1'b1;
        state_next = last_step ? S_DONE : S_RUN;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          load       = 1'b1;
          state_next = S_RUN;
        end else begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  booth_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .a        (a_r),
    .q        (q_r),
    .q_m1     (q_m1_r),
    .m        (m_r),
    .a_nxt    (a_nxt),
    .q_nxt    (q_nxt),
    .q_m1_nxt (q_m1_nxt)
  );

  // M is held sign-extended by one bit so that subtracting the most negative
  // operand cannot overflow A.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r     <= '0;
      q_r     <= '0;
      q_m1_r  <= 1'b0;
      m_r     <= '0;
      count   <= '0;
      product <= '0;
    end else if (load) begin
      a_r     <= '0;
      q_r     <= multiplier;
      q_m1_r  <= 1'b0;
      m_r     <= {multiplicand[WIDTH-1], multiplicand};
      count   <= CW'(WIDTH);
    end else if (step) begin
      a_r     <= a_nxt;
      q_r     <= q_nxt;
      q_m1_r  <= q_m1_nxt;
      count   <= count - CW'(1);
      if (last_step) begin
        product <= {a_nxt[WIDTH-1:0], q_nxt};
      end
    end
  end

endmodule

// File: tb/tb_booth_multiplier_sequencer.sv
// Self-checking bench for booth_multiplier_sequencer: directed corner cases and
// handshake scenarios, then random operands against an arithmetic reference.
module tb_booth_multiplier_sequencer;

  localparam int W = 8;
  localparam int TIMEOUT = 64;

  logic           clk;
  logic           rst;
  logic           start;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  logic [2*W-1:0] exp_q[$];
  int checks;
  int failures;

  booth_multiplier_sequencer #(
    .WIDTH(W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain signed multiplication truncated to the product width.
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] m, input logic [W-1:0] q);
    int p;
    p = $signed(m) * $signed(q);
    return p[2*W-1:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver: present operands with start for one edge, then scramble the inputs.
  // Returns at the negedge of the first RUN cycle.
  task automatic start_op(input logic [W-1:0] m, input logic [W-1:0] q);
    @(negedge clk);
    multiplicand = m;
    multiplier   = q;
    start        = 1'b1;
    exp_q.push_back(ref_mul(m, q));
    @(negedge clk);
    start        = 1'b0;
    multiplicand = W'($urandom);
    multiplier   = W'($urandom);
  endtask

  // Waits (bounded) for done; counts busy cycles seen on the way.
  task automatic wait_done(output int nbusy, output bit seen);
    nbusy = 0;
    seen  = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) nbusy++;
      @(negedge clk);
    end
  endtask

  task automatic finish_op(input string tag, input int exp_busy);
    int nb;
    bit seen;
    logic [2*W-1:0] exp;
    wait_done(nb, seen);
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_busy_cycles"}, 32'(nb), 32'(exp_busy));
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check({tag, "_product"}, 32'(product), 32'(exp));
  endtask

  initial begin
    int nb;
    bit seen;
    bit done_after_rst;
    logic [2*W-1:0] held;
    logic [W-1:0] rm;
    logic [W-1:0] rq;

    checks       = 0;
    failures     = 0;
    rst          = 1'b1;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_product", 32'(product), 32'd0);

    // 3 x 5: eight busy cycles, one-cycle done
    start_op(8'd3, 8'd5);
    finish_op("m3q5", W);
    check("m3q5_literal", 32'(product), 32'h000F);
    @(negedge clk);
    check("m3q5_done_one_cycle", 32'(done), 32'd0);
    check("m3q5_busy_after", 32'(busy), 32'd0);

    start_op(8'hF9, 8'd6);
    finish_op("m_7q6", W);
    check("m_7q6_literal", 32'(product), 32'hFFD6);

    start_op(8'h00, 8'h80);
    finish_op("m0q80", W);

    // Most-negative corner cases
    start_op(8'h80, 8'h80);
    finish_op("m80q80", W);
    check("m80q80_literal", 32'(product), 32'h4000);
    start_op(8'h80, 8'h7F);
    finish_op("m80q7f", W);
    check("m80q7f_literal", 32'(product), 32'hC080);
    start_op(8'h7F, 8'h7F);
    finish_op("m7fq7f", W);
    check("m7fq7f_literal", 32'(product), 32'h3F01);

    // Product holds while idle
    held = product;
    repeat (3) @(negedge clk);
    check("idle_product_hold", 32'(product), 32'(held));

    // start during RUN is ignored
    start_op(8'd2, 8'd3);
    repeat (3) @(negedge clk);
    start        = 1'b1;
    multiplicand = 8'd9;
    multiplier   = 8'd9;
    @(negedge clk);
    start = 1'b0;
    finish_op("ignore_start", W - 4);
    check("ignore_start_literal", 32'(product), 32'h0006);
    @(negedge clk);
    check("ignore_start_done_one", 32'(done), 32'd0);
    check("ignore_start_no_rerun", 32'(busy), 32'd0);

    // Back-to-back: start held during DONE
    start_op(8'd5, 8'd5);
    finish_op("b2b_first", W);
    check("b2b_first_literal", 32'(product), 32'h0019);
    start        = 1'b1;
    multiplicand = 8'd4;
    multiplier   = 8'hFF;
    exp_q.push_back(ref_mul(8'd4, 8'hFF));
    @(negedge clk);
    start = 1'b0;
    check("b2b_no_idle", 32'(busy), 32'd1);
    check("b2b_done_low", 32'(done), 32'd0);
    finish_op("b2b_second", W);
    check("b2b_second_literal", 32'(product), 32'hFFFC);

    // Reset in the middle of a run
    start_op(8'd12, 8'd12);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_product", 32'(product), 32'd0);
    done_after_rst = 1'b0;
    for (int i = 0; i < W + 4; i++) begin
      if (done || busy) done_after_rst = 1'b1;
      @(negedge clk);
    end
    check("midrst_no_done", 32'(done_after_rst), 32'd0);
    start_op(8'd12, 8'd12);
    finish_op("midrst_fresh", W);
    check("midrst_fresh_literal", 32'(product), 32'h0090);

    // Random operands, random idle gaps, some back-to-back
    for (int n = 0; n < 24; n++) begin
      rm = W'($urandom);
      rq = W'($urandom);
      if (done && $urandom_range(0, 1) == 1) begin
        start        = 1'b1;
        multiplicand = rm;
        multiplier   = rq;
        exp_q.push_back(ref_mul(rm, rq));
        @(negedge clk);
        start        = 1'b0;
        multiplicand = W'($urandom);
        multiplier   = W'($urandom);
      end else begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        start_op(rm, rq);
      end
      wait_done(nb, seen);
      check("rand_done_seen", 32'(seen), 32'd1);
      check("rand_busy_cycles", 32'(nb), 32'(W));
      check("rand_product", 32'(product), 32'(exp_q.size() > 0 ? exp_q.pop_front() : '0));
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
